// File: rtl/dmem_pkg.sv
// dmem_pkg: shared MMIO offsets, status bit indices and address-region decode
package dmem_pkg;
  localparam logic [3:0] OFF_CYCLE_LO = 4'h0;
  localparam logic [3:0] OFF_CYCLE_HI = 4'h4;
  localparam logic [3:0] OFF_TOHOST   = 4'h8;
  localparam logic [3:0] OFF_STATUS   = 4'hC;
  localparam int ST_FAULT = 0;
  localparam int ST_HALT  = 1;
  typedef enum logic [1:0] {REG_RAM, REG_MMIO, REG_UNMAPPED} region_e;
  function automatic region_e decode_region(logic [31:0] a, int unsigned aw, logic [31:0] base);
    if ((a >> (aw + 2)) == 32'd0) return REG_RAM;
    if (((a ^ base) >> 4) == 32'd0) return REG_MMIO;
    return REG_UNMAPPED;
  endfunction
endpackage

// File: rtl/dmem_ram_bytelane.sv
// dmem_ram_bytelane: DEPTH x 32 word RAM with per-lane write enables and async read
module dmem_ram_bytelane #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: CPU data-memory responder with byte-lane RAM and a small MMIO page
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = 4096,
  parameter int          AW        = 12,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_read,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_write,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        halt,
  output logic        fault
);
  logic [63:0] r_cnt;
  logic [31:0] r_hi_snap, r_tohost;
  logic [31:2] r_fault_addr;
  logic        r_halt, r_fault;
  region_e     w_region;
  logic [3:0]  w_off, w_ram_we;
  logic [31:0] w_ram_rdata, w_mmio_rdata, w_mask, w_tohost_next;
  logic        w_mmio, w_tohost_wr, w_fault_set, w_fault_clr;
  assign w_region      = decode_region(data_addr, AW, MMIO_BASE);
  assign w_mmio        = w_region == REG_MMIO;
  assign w_off         = {data_addr[3:2], 2'b00};
  assign w_mask        = {{8{data_write[3]}}, {8{data_write[2]}}, {8{data_write[1]}}, {8{data_write[0]}}};
  assign w_tohost_next = (r_tohost & ~w_mask) | (data_in & w_mask);
  assign w_tohost_wr   = w_mmio && w_off == OFF_TOHOST && |data_write && !r_halt;
  assign w_fault_set   = w_region == REG_UNMAPPED && (data_read || |data_write);
  assign w_fault_clr   = w_mmio && w_off == OFF_STATUS && data_write[0] && data_in[ST_FAULT];
  // gating with rst keeps a write in flight at reset assertion from landing
  assign w_ram_we      = (w_region == REG_RAM && !r_halt && rst) ? data_write : 4'b0;
  dmem_ram_bytelane #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (data_addr[AW+1:2]),
    .i_wdata (data_in),
    .o_rdata (w_ram_rdata)
  );
  always_comb begin
    w_mmio_rdata = w_off == OFF_CYCLE_LO ? r_cnt[31:0] :
                   w_off == OFF_CYCLE_HI ? r_hi_snap :
                   w_off == OFF_TOHOST   ? r_tohost :
                   {r_fault_addr, r_halt, r_fault};
    data_out     = (!rst || !data_read)  ? 32'h0 :
                   w_region == REG_RAM   ? w_ram_rdata :
                   w_mmio                ? w_mmio_rdata : 32'h0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt        <= '0;
      r_hi_snap    <= '0;
      r_tohost     <= '0;
      r_halt       <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else begin
      if (!r_halt) r_cnt <= r_cnt + 64'd1;
      if (data_read && w_mmio && w_off == OFF_CYCLE_LO) r_hi_snap <= r_cnt[63:32];
      if (w_tohost_wr) begin
        r_tohost <= w_tohost_next;
        if (|w_tohost_next) r_halt <= 1'b1;
      end
      // a new fault beats a same-cycle clear and re-captures the address
      r_fault <= w_fault_set | (r_fault & ~w_fault_clr);
      if (w_fault_set && (!r_fault || w_fault_clr)) r_fault_addr <= data_addr[31:2];
    end
  end
  assign halt  = r_halt;
  assign fault = r_fault;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder
module tb_dmem_responder;
  localparam logic [31:0] MB = 32'hFFFF_0000;
  logic        clk = 1'b0, rst = 1'b0, data_read = 1'b0, halt, fault;
  logic [31:0] data_addr = '0, data_in = '0, data_out;
  logic [3:0]  data_write = '0;
  logic [31:0] v_saved;
  int n_chk = 0, n_fail = 0;
  dmem_responder dut (
    .clk(clk), .rst(rst), .data_read(data_read), .data_addr(data_addr),
    .data_write(data_write), .data_in(data_in), .data_out(data_out),
    .halt(halt), .fault(fault)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    data_addr = a; data_in = d; data_write = s; data_read = 1'b0;
    tick;
    data_write = '0;
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e);
    data_addr = a; data_read = 1'b1;
    #1 chk(tag, data_out, e);
    tick;
    data_read = 1'b0;
  endtask
  initial begin
    data_read = 1'b1;
    #2;
    chk("reset_dout", data_out, 32'h0);
    chk("reset_halt", {31'b0, halt}, 32'h0);
    chk("reset_fault", {31'b0, fault}, 32'h0);
    data_read = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    wr(32'h10, 32'hAABBCCDD, 4'hF);
    wr(32'h10, 32'h00000011, 4'h1);
    rd("lane_lo", 32'h10, 32'hAABBCC11);
    wr(32'h10, 32'h12340000, 4'hC);
    rd("lane_hi", 32'h10, 32'h1234CC11);
    rd("no_read_zero", 32'h10, 32'h1234CC11);
    data_addr = 32'h10; #1 chk("read_off", data_out, 32'h0);
    wr(32'h20, 32'h5, 4'hF);
    data_addr = 32'h20; data_in = 32'h9; data_write = 4'hF; data_read = 1'b1;
    #1 chk("rdw_old", data_out, 32'h5);
    tick;
    data_write = '0;
    chk("rdw_new", data_out, 32'h9);
    data_read = 1'b0;
    force dut.r_cnt = 64'h0000_0000_FFFF_FFFF;
    rd("cyc_lo_pre", MB, 32'hFFFF_FFFF);
    release dut.r_cnt;
    repeat (3) tick;
    rd("cyc_hi_snap", MB + 32'h4, 32'h0);
    rd("cyc_lo_live", MB, 32'h3);
    rd("cyc_hi_new", MB + 32'h4, 32'h1);
    wr(MB + 32'h4, 32'hDEAD, 4'hF);
    chk("ro_write_nofault", {31'b0, fault}, 32'h0);
    rd("unmapped_rd", 32'h8000_0000, 32'h0);
    chk("fault_set", {31'b0, fault}, 32'h1);
    rd("status_fault", MB + 32'hC, 32'h8000_0001);
    rd("unmapped_rd2", 32'h9000_0000, 32'h0);
    rd("status_first_wins", MB + 32'hC, 32'h8000_0001);
    wr(MB + 32'hC, 32'h1, 4'h1);
    chk("fault_clr", {31'b0, fault}, 32'h0);
    wr(32'h8000_0010, 32'h1, 4'hF);
    chk("unmapped_wr_fault", {31'b0, fault}, 32'h1);
    wr(MB + 32'hC, 32'h1, 4'h1);
    wr(32'h0, 32'h12345678, 4'hF);
    chk("halt_pre", {31'b0, halt}, 32'h0);
    wr(MB + 32'h8, 32'h1, 4'h1);
    chk("halt_set", {31'b0, halt}, 32'h1);
    rd("tohost_rd", MB + 32'h8, 32'h1);
    data_addr = MB; data_read = 1'b1;
    #1 v_saved = data_out;
    repeat (3) tick;
    chk("cnt_frozen", data_out, v_saved);
    data_read = 1'b0;
    wr(32'h0, 32'hFF, 4'hF);
    rd("halt_ram_kept", 32'h0, 32'h12345678);
    wr(MB + 32'h8, 32'h0, 4'hF);
    rd("halt_tohost_kept", MB + 32'h8, 32'h1);
    rd("unmapped_halted", 32'h4000_0000, 32'h0);
    rd("status_halt_fault", MB + 32'hC, 32'h4000_0003);
    wr(MB + 32'hC, 32'h1, 4'h1);
    rd("status_clr_halted", MB + 32'hC, 32'h4000_0002);
    data_addr = 32'h10; data_in = 32'hFFFF_FFFF; data_write = 4'hF; data_read = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_dout", data_out, 32'h0);
    chk("rst_halt", {31'b0, halt}, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'h0);
    tick;
    data_write = '0; data_read = 1'b0;
    rst = 1'b1;
    rd("rst_cnt", MB, 32'h0);
    rd("rst_ram_10", 32'h10, 32'h1234CC11);
    rd("rst_ram_20", 32'h20, 32'h9);
    rd("rst_ram_0", 32'h0, 32'h12345678);
    rd("rst_status", MB + 32'hC, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
